// File: rtl/single_port_ram_if.sv
// Bus bundle for single_port_ram: shared address, write data/enable and read data.
// The master drives the address and write side; the RAM (slave) returns q.
interface single_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] data;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [DATA_WIDTH-1:0] q;

  modport master (
    output data,
    output addr,
    output we,
    input  q
  );

  modport slave (
    input  data,
    input  addr,
    input  we,
    output q
  );
endinterface

// File: rtl/single_port_ram.sv
// 64x8 synchronous single-port RAM with a registered address and a write-first
// combinational read port; asynchronous reset clears the address and every word.
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  single_port_ram_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_reg;

  // NOTE: the array is deliberately reset so that no word ever reads X; this
  // keeps it in flops rather than a RAM macro, which is acceptable at 64x8.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (bus.we) begin
        mem[bus.addr] <= bus.data;
      end
      addr_reg <= bus.addr;
    end
  end

  // Reading through the registered address after the write lands gives write-first data.
  assign bus.q = mem[addr_reg];

endmodule

// File: tb/tb_single_port_ram.sv
// Directed plus randomized bench for single_port_ram, checked against a simple
// array model of the RAM and against hand-written expected constants.
module tb_single_port_ram;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk;
  logic rst_n;

  single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  single_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: the memory contents and the address seen at the last edge.
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_addr;

  task automatic check(input string tag, input logic [DW-1:0] observed,
                       input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_addr = 0;
  endtask

  // Drive one cycle's inputs, take the edge, update the model, then settle.
  task automatic apply(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we   = w;
    bus.addr = a;
    bus.data = d;
    @(posedge clk);
    if (rst_n) begin
      if (w) ref_mem[a] = d;
      ref_addr = int'(a);
    end
    #1;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, AW'(i), DW'($urandom));
      check(tag, bus.q, ref_mem[i]);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    model_clear();

    // Reset asserted between edges must clear q without a clock.
    #7;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", bus.q, 8'h00);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = 6'd5;
    bus.data = 8'hee;
    @(posedge clk);
    #1;
    check("reset_ignores_edge", bus.q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    apply(1'b0, 6'd5, 8'h00);
    check("post_reset_read5", bus.q, 8'h00);

    // Write burst: each written word appears on q right after its edge.
    apply(1'b1, 6'd1, 8'h01); check("burst_w1", bus.q, 8'h01);
    apply(1'b1, 6'd2, 8'ha2); check("burst_w2", bus.q, 8'ha2);
    apply(1'b1, 6'd3, 8'hb3); check("burst_w3", bus.q, 8'hb3);
    apply(1'b0, 6'd2, 8'h00); check("read2", bus.q, 8'ha2);
    apply(1'b0, 6'd1, 8'h00); check("read1", bus.q, 8'h01);
    apply(1'b0, 6'd3, 8'h00); check("read3", bus.q, 8'hb3);

    // High addresses.
    apply(1'b1, 6'd50, 8'hdf); check("w50", bus.q, 8'hdf);
    apply(1'b1, 6'd51, 8'hbf); check("w51", bus.q, 8'hbf);
    apply(1'b0, 6'd50, 8'h00); check("read50", bus.q, 8'hdf);
    apply(1'b0, 6'd51, 8'h00); check("read51", bus.q, 8'hbf);
    apply(1'b0, 6'd1, 8'h00);  check("reread1", bus.q, 8'h01);
    apply(1'b0, 6'd2, 8'h00);  check("reread2", bus.q, 8'ha2);
    apply(1'b0, 6'd3, 8'h00);  check("reread3", bus.q, 8'hb3);

    // Boundary addresses and overwrite.
    apply(1'b1, 6'd0, 8'h55);  check("w0", bus.q, 8'h55);
    apply(1'b1, 6'd63, 8'haa); check("w63", bus.q, 8'haa);
    apply(1'b0, 6'd0, 8'h00);  check("read0", bus.q, 8'h55);
    apply(1'b0, 6'd63, 8'h00); check("read63", bus.q, 8'haa);
    apply(1'b1, 6'd63, 8'h3c); check("rewrite63", bus.q, 8'h3c);
    apply(1'b0, 6'd63, 8'h00); check("reread63", bus.q, 8'h3c);
    apply(1'b0, 6'd62, 8'h00); check("read62_untouched", bus.q, 8'h00);

    // Read-only hold with random data on the bus.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 6'd2, DW'($urandom));
      check("hold2", bus.q, 8'ha2);
    end
    sweep("sweep_after_hold");

    // Randomized traffic checked against the model.
    for (int i = 0; i < 300; i++) begin
      apply(1'($urandom), AW'($urandom), DW'($urandom));
      check("random", bus.q, ref_mem[ref_addr]);
    end
    sweep("sweep_after_random");

    // Re-establish known contents, then reset in the middle of a write.
    apply(1'b1, 6'd1, 8'h01);
    apply(1'b1, 6'd2, 8'ha2);
    apply(1'b1, 6'd50, 8'hdf);
    bus.we   = 1'b1;
    bus.addr = 6'd4;
    bus.data = 8'h77;
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check("midop_reset_immediate", bus.q, 8'h00);
    @(posedge clk);
    #1;
    check("midop_reset_held", bus.q, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 6'd1, 8'h00);  check("after_reset1", bus.q, 8'h00);
    apply(1'b0, 6'd2, 8'h00);  check("after_reset2", bus.q, 8'h00);
    apply(1'b0, 6'd50, 8'h00); check("after_reset50", bus.q, 8'h00);
    apply(1'b0, 6'd4, 8'h00);  check("after_reset4", bus.q, 8'h00);
    sweep("sweep_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
